// File: rtl/switch_debounce_sync.sv
// Per-bit 2-FF synchronizer and debounce counter for board switches and
// keys, reporting the accepted level plus one-cycle rise/fall pulses.
module switch_debounce_sync #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] stable_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   localparam longint LAST_L = longint'(DEBOUNCE_CYCLES) - 1;
   localparam longint MAX_L  = (longint'(1) << CNT_W) - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_L);

   // Reject parameter sets whose counter cannot hold the last count value
   if (DEBOUNCE_CYCLES < 1 || LAST_L > MAX_L) begin : g_bad_params
      $error("switch_debounce_sync: CNT_W too small for DEBOUNCE_CYCLES");
   end

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] accept;

   // Double-flop synchronizer; only sync2 is used downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_raw;
         sync2 <= sync1;
      end
   end

   // A bit is accepted on the edge that completes its mismatch window
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (sync2[i] != stable_out[i]) && (cnt[i] == LAST);
      end
   end

   // Per-bit mismatch counters; any return to the stable value restarts them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable_out[i] || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Stable level and edge pulses updated together on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_out <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         any_change <= 1'b0;
      end else begin
         stable_out <= (stable_out & ~accept) | (sync2 & accept);
         rise_pulse <= accept & sync2;
         fall_pulse <= accept & ~sync2;
         any_change <= |accept;
      end
   end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: per-cycle vector table fed through an
// expectation queue, plus hand-written reset sequences.
module tb_switch_debounce_sync;

   logic       clk;
   logic       rst_n;
   logic [9:0] in_raw;
   logic [9:0] stable_out;
   logic [9:0] rise_pulse;
   logic [9:0] fall_pulse;
   logic       any_change;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [9:0] in;
      logic [9:0] st;
      logic [9:0] ri;
      logic [9:0] fa;
      logic       an;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   switch_debounce_sync #(
      .WIDTH(10),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_raw(in_raw),
      .stable_out(stable_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .any_change(any_change)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [9:0] act,
                        input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " stable"}, stable_out, 10'h000);
      check({tag, " rise"}, rise_pulse, 10'h000);
      check({tag, " fall"}, fall_pulse, 10'h000);
      check({tag, " any"}, {9'd0, any_change}, 10'h000);
   endtask

   function automatic void add(input logic [9:0] in, input logic [9:0] st,
                               input logic [9:0] ri, input logic [9:0] fa,
                               input logic an);
      vec_t v;
      v.in = in;
      v.st = st;
      v.ri = ri;
      v.fa = fa;
      v.an = an;
      vecs.push_back(v);
   endfunction

   function automatic void add_n(input int n, input logic [9:0] in,
                                 input logic [9:0] st);
      for (int k = 0; k < n; k++) add(in, st, 10'h000, 10'h000, 1'b0);
   endfunction

   // Each row: drive at negedge, queue its expectation, compare after edge
   task automatic run_vecs(input string tag);
      vec_t e;
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         in_raw = vecs[r].in;
         exp_q.push_back(vecs[r]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("%s[%0d] stable", tag, r), stable_out, e.st);
         check($sformatf("%s[%0d] rise", tag, r), rise_pulse, e.ri);
         check($sformatf("%s[%0d] fall", tag, r), fall_pulse, e.fa);
         check($sformatf("%s[%0d] any", tag, r), {9'd0, any_change},
               {9'd0, e.an});
      end
      vecs.delete();
   endtask

   initial begin
      rst_n  = 1'b1;
      in_raw = 10'h3FF;
      #2 rst_n = 1'b0;
      #1 check_zero("reset_async");
      repeat (3) begin
         @(posedge clk);
         #1 check_zero("reset_hold");
      end
      @(negedge clk);
      in_raw = 10'h000;
      rst_n  = 1'b1;

      // clean rise on bit 0
      add_n(5, 10'h001, 10'h000);
      add(10'h001, 10'h001, 10'h001, 10'h000, 1'b1);
      add_n(2, 10'h001, 10'h001);
      // bounce on bit 3 rejected
      for (int k = 0; k < 20; k++) begin
         add_n(1, (k % 2 == 0) ? 10'h009 : 10'h001, 10'h001);
      end
      add_n(6, 10'h001, 10'h001);
      // near miss on bit 5, then a 4-cycle pulse accepted and released
      add_n(3, 10'h021, 10'h001);
      add_n(6, 10'h001, 10'h001);
      add_n(4, 10'h021, 10'h001);
      add_n(1, 10'h001, 10'h001);
      add(10'h001, 10'h021, 10'h020, 10'h000, 1'b1);
      add_n(3, 10'h001, 10'h021);
      add(10'h001, 10'h001, 10'h000, 10'h020, 1'b1);
      add_n(2, 10'h001, 10'h001);
      // all bits high, then all fall together
      add_n(5, 10'h3FF, 10'h001);
      add(10'h3FF, 10'h3FF, 10'h3FE, 10'h000, 1'b1);
      add_n(2, 10'h3FF, 10'h3FF);
      add_n(5, 10'h000, 10'h3FF);
      add(10'h000, 10'h000, 10'h000, 10'h3FF, 1'b1);
      add_n(2, 10'h000, 10'h000);
      run_vecs("main");

      // reset in the middle of a bit-7 count
      @(negedge clk);
      in_raw = 10'h080;
      repeat (4) @(posedge clk);
      #1 check("midcount stable", stable_out, 10'h000);
      #2 rst_n = 1'b0;
      #1 check_zero("midcount_reset");
      @(posedge clk);
      #1 check_zero("midcount_hold");
      #1 rst_n = 1'b1;
      add_n(5, 10'h080, 10'h000);
      add(10'h080, 10'h080, 10'h080, 10'h000, 1'b1);
      add_n(2, 10'h080, 10'h080);
      run_vecs("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
